p405s_dsocm_ctrl: RTL and testbench
===================================

# p405s_dsocm_ctrl

Parametrised data-side OCM controller for the PPC405 core: decodes DSOCM load/store requests against a configurable base address, serves them from an internal byte-writable word memory with programmable read/write wait states, and handles abort and out-of-range requests. It sits between the C405 DSOCM port and on-chip data RAM. It is the successor to the fixed-latency, single-size DSOCM shell.

## Interface
Parameters:
- ADDR_W, 11: word-address bits decoded locally; memory depth 2^ADDR_W 32-bit words.
- BASE_ADDR, 30'h0: word base address; only bits [29:ADDR_W] are compared.
- RD_WAIT, 0: extra wait cycles for loads, range 0..15.
- WR_WAIT, 0: extra wait cycles for stores, range 0..15.

Ports:
- SystemClock  in  1  sole clock; all state updates on the rising edge.
- dsocm_if_reset  in  1  reset, synchronous, active-high.
- dsocm_if_C405_dsocmLoadReq  in  1  load request, single-cycle strobe.
- dsocm_if_C405_dsocmStoreReq  in  1  store request, single-cycle strobe.
- dsocm_if_C405_dsocmABus  in  30  word address, valid with a request.
- dsocm_if_C405_dsocmByteEn  in  4  byte enables; bit i controls WrDBus[8i+7:8i].
- dsocm_if_C405_dsocmWrDBus  in  32  store data, valid with StoreReq.
- dsocm_if_C405_dsocmAbortReq  in  1  cancels the outstanding access.
- dsocm_if_DSOCM_c405Complete  out  1  one-cycle completion pulse.
- dsocm_if_DSOCM_c405RdDBus  out  32  load data, valid only while Complete=1; 0 otherwise.
- dsocm_if_DSOCM_c405Hold  out  1  tied 0.
- dsocm_if_DSOCM_c405DisOperandFwd  out  1  tied 0.
- dsocm_range_err  out  1  one-cycle pulse when an out-of-range request is rejected.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- A request is sampled in IDLE or DONE:
  - LoadReq has priority; if LoadReq and StoreReq are both high, the store is ignored.
  - In range means ABus[29:ADDR_W] == BASE_ADDR[29:ADDR_W].
- An in-range request latches the address, byte enables, write data and the read/write flag.
  - If its wait count (RD_WAIT or WR_WAIT) is 0, the next state is DONE.
  - Otherwise the next state is WAIT with cnt = wait-1.
- An out-of-range request is not accessed and gets no Complete. range_err pulses the next cycle, and the FSM goes to or stays in IDLE.
- In WAIT:
  - AbortReq=1 returns to IDLE, with no write, no Complete and no range_err.
  - Otherwise, if cnt==0 go to DONE; else decrement cnt.
  - Requests arriving in WAIT are ignored, not queued.
- Memory access happens on the edge entering DONE:
  - Store: write only the enabled byte lanes at ABus[ADDR_W-1:0]. ByteEn=0 completes without modifying memory.
  - Load: register the full word into the read-data register.
- DONE asserts Complete=1 and drives RdDBus (loads) for exactly one cycle. AbortReq is ignored in DONE. A new request sampled in DONE is processed as from IDLE (back-to-back accesses).
- Stores in DONE drive RdDBus=0.
- Reset: state IDLE, Complete=0, RdDBus=0, range_err=0, cnt=0. A pending access is discarded; a store not yet committed never reaches memory. Memory contents are not reset.

## Timing
- Cycle 0 is the request cycle (sampled at the end of cycle 0).
- Load latency: Complete and RdDBus are valid in cycle RD_WAIT+1.
- Store latency: Complete is valid in cycle WR_WAIT+1; the data is visible to a load sampled in that same cycle.
- Maximum throughput is one access per (wait+1) cycles.
- Abort window: cycles 1..wait. With wait=0, an access cannot be aborted.
- range_err is high in cycle 1 only.
- Hold and DisOperandFwd are 0 at all times.

## Test plan
- Load/store sequence, RD_WAIT=0, WR_WAIT=0, BASE_ADDR=0:
  - Store 32'hDEADBEEF, ByteEn=4'hF at word 5 -> Complete in cycle 1.
  - Load word 5 in cycle 1 -> Complete in cycle 2 with RdDBus=DEADBEEF; RdDBus=0 in cycle 3.
- Byte lanes: word 5=DEADBEEF, store 32'h11223344 with ByteEn=4'b0101 -> load returns 32'hDE22BE44.
- Wait states, RD_WAIT=3:
  - Load issued -> Complete only in cycle 4; no Complete in cycles 1-3.
  - A second LoadReq in cycle 2 is ignored: exactly one Complete.
- Abort, WR_WAIT=2:
  - Store AAAA5555 to word 7 with AbortReq in cycle 1 -> no Complete; a later load of word 7 returns the old value.
  - AbortReq in the DONE cycle is ignored.
- Range, ADDR_W=11, BASE_ADDR=30'h800:
  - Load at 30'h000 -> range_err in cycle 1, no Complete.
  - Load at 30'h805 -> normal completion.
- Reset and simultaneous requests:
  - Store with WR_WAIT=3, dsocm_if_reset in cycle 2 -> all outputs 0 and memory unchanged.
  - LoadReq and StoreReq together -> a load is performed and memory is unchanged.

Source files
------------

// File: rtl/p405s_dsocm_ctrl.sv
// Data-side OCM controller for the PPC405. It decodes loads and stores against BASE_ADDR and serves them from a
// byte-writable word RAM. Latency is wait+1 cycles. There is no backpressure: requests arriving during WAIT are dropped.
module p405s_dsocm_ctrl #(
  parameter int unsigned ADDR_W    = 11,
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter int unsigned RD_WAIT   = 0,
  parameter int unsigned WR_WAIT   = 0
) (
  input  logic        SystemClock,
  input  logic        dsocm_if_reset,
  input  logic        dsocm_if_C405_dsocmLoadReq,
  input  logic        dsocm_if_C405_dsocmStoreReq,
  input  logic [29:0] dsocm_if_C405_dsocmABus,
  input  logic [3:0]  dsocm_if_C405_dsocmByteEn,
  input  logic [31:0] dsocm_if_C405_dsocmWrDBus,
  input  logic        dsocm_if_C405_dsocmAbortReq,
  output logic        dsocm_if_DSOCM_c405Complete,
  output logic [31:0] dsocm_if_DSOCM_c405RdDBus,
  output logic        dsocm_if_DSOCM_c405Hold,
  output logic        dsocm_if_DSOCM_c405DisOperandFwd,
  output logic        dsocm_range_err
);

  localparam logic [3:0] RdWait = 4'(RD_WAIT);
  localparam logic [3:0] WrWait = 4'(WR_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, nextState;
  logic [3:0]        cnt, nextCnt;
  logic [ADDR_W-1:0] addrQ;
  logic [3:0]        byteEnQ;
  logic [31:0]       wrDataQ;
  logic              isReadQ;
  logic [31:0]       rdDataQ;
  logic              rangeErrQ;
  logic [31:0]       mem [2**ADDR_W];

  logic              reqVld, reqRead, inRange, accept, reject, enterDone;
  logic [3:0]        reqWait;
  logic [ADDR_W-1:0] accAddr;
  logic [3:0]        accByteEn;
  logic [31:0]       accData;
  logic              accRead;

  assign reqVld  = (state != WAIT) &&
                   (dsocm_if_C405_dsocmLoadReq || dsocm_if_C405_dsocmStoreReq);
  assign reqRead = dsocm_if_C405_dsocmLoadReq;
  assign inRange = dsocm_if_C405_dsocmABus[29:ADDR_W] == BASE_ADDR[29:ADDR_W];
  assign accept  = reqVld && inRange;
  assign reject  = reqVld && !inRange;
  assign reqWait = reqRead ? RdWait : WrWait;

  // Zero-wait accesses commit straight from the bus; waited ones use the latched copy.
  assign accAddr   = (state == WAIT) ? addrQ   : dsocm_if_C405_dsocmABus[ADDR_W-1:0];
  assign accByteEn = (state == WAIT) ? byteEnQ : dsocm_if_C405_dsocmByteEn;
  assign accData   = (state == WAIT) ? wrDataQ : dsocm_if_C405_dsocmWrDBus;
  assign accRead   = (state == WAIT) ? isReadQ : reqRead;
  assign enterDone = (nextState == DONE) && !dsocm_if_reset;

  always_ff @(posedge SystemClock) begin
    if (dsocm_if_reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdDataQ   <= 32'd0;
      rangeErrQ <= 1'b0;
      addrQ     <= '0;
      byteEnQ   <= 4'd0;
      wrDataQ   <= 32'd0;
      isReadQ   <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      rangeErrQ <= reject;
      rdDataQ   <= (enterDone && accRead) ? mem[accAddr] : 32'd0;
      if (accept) begin
        addrQ   <= dsocm_if_C405_dsocmABus[ADDR_W-1:0];
        byteEnQ <= dsocm_if_C405_dsocmByteEn;
        wrDataQ <= dsocm_if_C405_dsocmWrDBus;
        isReadQ <= reqRead;
      end
    end
  end

  always_ff @(posedge SystemClock) begin
    if (enterDone && !accRead) begin
      for (int b = 0; b < 4; b++) begin
        if (accByteEn[b]) mem[accAddr][8*b +: 8] <= accData[8*b +: 8];
      end
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (reqWait == 4'd0) begin
            nextState = DONE;
          end else begin
            nextState = WAIT;
            nextCnt   = reqWait - 4'd1;
          end
        end else begin
          nextState = IDLE;
        end
      end
      WAIT: begin
        if (dsocm_if_C405_dsocmAbortReq) nextState = IDLE;
        else if (cnt == 4'd0)            nextState = DONE;
        else                             nextCnt   = cnt - 4'd1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    dsocm_if_DSOCM_c405Complete      = (state == DONE);
    dsocm_if_DSOCM_c405RdDBus        = rdDataQ;
    dsocm_if_DSOCM_c405Hold          = 1'b0;
    dsocm_if_DSOCM_c405DisOperandFwd = 1'b0;
    dsocm_range_err                  = rangeErrQ;
  end

endmodule

// File: tb/tb_p405s_dsocm_ctrl.sv
// Directed bench for p405s_dsocm_ctrl. It uses three instances: zero-wait, waited (RD 3 / WR 2),
// and offset base with WR 3.
module tb_p405s_dsocm_ctrl;

  logic        SystemClock = 1'b0;
  logic        rst      [3];
  logic        loadReq  [3];
  logic        storeReq [3];
  logic [29:0] aBus     [3];
  logic [3:0]  byteEn   [3];
  logic [31:0] wrDBus   [3];
  logic        abortReq [3];
  logic        complete [3];
  logic [31:0] rdDBus   [3];
  logic        hold     [3];
  logic        disFwd   [3];
  logic        rangeErr [3];

  int testsRun = 0;
  int testsFailed = 0;
  int nCmpl;

  always #5 SystemClock = ~SystemClock;

  p405s_dsocm_ctrl #(.ADDR_W(11), .BASE_ADDR(30'h0), .RD_WAIT(0), .WR_WAIT(0)) u0 (
    .SystemClock(SystemClock), .dsocm_if_reset(rst[0]),
    .dsocm_if_C405_dsocmLoadReq(loadReq[0]), .dsocm_if_C405_dsocmStoreReq(storeReq[0]),
    .dsocm_if_C405_dsocmABus(aBus[0]), .dsocm_if_C405_dsocmByteEn(byteEn[0]),
    .dsocm_if_C405_dsocmWrDBus(wrDBus[0]), .dsocm_if_C405_dsocmAbortReq(abortReq[0]),
    .dsocm_if_DSOCM_c405Complete(complete[0]), .dsocm_if_DSOCM_c405RdDBus(rdDBus[0]),
    .dsocm_if_DSOCM_c405Hold(hold[0]), .dsocm_if_DSOCM_c405DisOperandFwd(disFwd[0]),
    .dsocm_range_err(rangeErr[0]));

  p405s_dsocm_ctrl #(.ADDR_W(11), .BASE_ADDR(30'h0), .RD_WAIT(3), .WR_WAIT(2)) u1 (
    .SystemClock(SystemClock), .dsocm_if_reset(rst[1]),
    .dsocm_if_C405_dsocmLoadReq(loadReq[1]), .dsocm_if_C405_dsocmStoreReq(storeReq[1]),
    .dsocm_if_C405_dsocmABus(aBus[1]), .dsocm_if_C405_dsocmByteEn(byteEn[1]),
    .dsocm_if_C405_dsocmWrDBus(wrDBus[1]), .dsocm_if_C405_dsocmAbortReq(abortReq[1]),
    .dsocm_if_DSOCM_c405Complete(complete[1]), .dsocm_if_DSOCM_c405RdDBus(rdDBus[1]),
    .dsocm_if_DSOCM_c405Hold(hold[1]), .dsocm_if_DSOCM_c405DisOperandFwd(disFwd[1]),
    .dsocm_range_err(rangeErr[1]));

  p405s_dsocm_ctrl #(.ADDR_W(11), .BASE_ADDR(30'h800), .RD_WAIT(0), .WR_WAIT(3)) u2 (
    .SystemClock(SystemClock), .dsocm_if_reset(rst[2]),
    .dsocm_if_C405_dsocmLoadReq(loadReq[2]), .dsocm_if_C405_dsocmStoreReq(storeReq[2]),
    .dsocm_if_C405_dsocmABus(aBus[2]), .dsocm_if_C405_dsocmByteEn(byteEn[2]),
    .dsocm_if_C405_dsocmWrDBus(wrDBus[2]), .dsocm_if_C405_dsocmAbortReq(abortReq[2]),
    .dsocm_if_DSOCM_c405Complete(complete[2]), .dsocm_if_DSOCM_c405RdDBus(rdDBus[2]),
    .dsocm_if_DSOCM_c405Hold(hold[2]), .dsocm_if_DSOCM_c405DisOperandFwd(disFwd[2]),
    .dsocm_range_err(rangeErr[2]));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; afterwards we sit 1 time unit past the rising edge.
  task automatic step();
    @(posedge SystemClock);
    #1;
  endtask

  task automatic setReq(input int i, input logic ld, input logic st, input logic [29:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    loadReq[i] = ld; storeReq[i] = st; aBus[i] = a; byteEn[i] = be; wrDBus[i] = d;
  endtask

  task automatic clearReq(input int i);
    setReq(i, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    abortReq[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      clearReq(i);
    end
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("rst_cmpl%0d", i), complete[i], 0);
      checkVal($sformatf("rst_rd%0d", i), rdDBus[i], 0);
      checkVal($sformatf("rst_rerr%0d", i), rangeErr[i], 0);
      checkVal($sformatf("hold%0d", i), hold[i], 0);
      checkVal($sformatf("disfwd%0d", i), disFwd[i], 0);
      rst[i] = 1'b0;
    end
    step();

    // Zero-wait store then back-to-back load
    setReq(0, 1'b0, 1'b1, 30'd5, 4'hF, 32'hDEADBEEF); step();
    checkVal("st_cmpl", complete[0], 1);
    checkVal("st_rd_zero", rdDBus[0], 0);
    setReq(0, 1'b1, 1'b0, 30'd5, 4'hF, 32'h0); step();
    checkVal("ld_cmpl", complete[0], 1);
    checkVal("ld_data", rdDBus[0], 32'hDEADBEEF);
    clearReq(0); step();
    checkVal("ld_cmpl_gone", complete[0], 0);
    checkVal("ld_rd_gone", rdDBus[0], 0);

    // Byte lanes 0 and 2 only
    setReq(0, 1'b0, 1'b1, 30'd5, 4'b0101, 32'h11223344); step();
    setReq(0, 1'b1, 1'b0, 30'd5, 4'hF, 32'h0); step();
    checkVal("lane_data", rdDBus[0], 32'hDE22BE44);
    // ByteEn=0 still completes but leaves memory untouched
    setReq(0, 1'b0, 1'b1, 30'd5, 4'h0, 32'hFFFFFFFF); step();
    checkVal("be0_cmpl", complete[0], 1);
    setReq(0, 1'b1, 1'b0, 30'd5, 4'hF, 32'h0); step();
    checkVal("be0_data", rdDBus[0], 32'hDE22BE44);
    // Simultaneous load+store: the load wins
    setReq(0, 1'b1, 1'b1, 30'd5, 4'hF, 32'h0); step();
    checkVal("both_cmpl", complete[0], 1);
    checkVal("both_data", rdDBus[0], 32'hDE22BE44);
    setReq(0, 1'b1, 1'b0, 30'd5, 4'hF, 32'h0); step();
    checkVal("both_mem", rdDBus[0], 32'hDE22BE44);
    clearReq(0); step();

    // Waited instance: preload word 7 (WR_WAIT=2 -> Complete in cycle 3)
    setReq(1, 1'b0, 1'b1, 30'd7, 4'hF, 32'h12345678); step();
    clearReq(1);
    checkVal("wst_c1", complete[1], 0); step();
    checkVal("wst_c2", complete[1], 0); step();
    checkVal("wst_c3", complete[1], 1); step();

    // RD_WAIT=3, second load in cycle 2 is dropped
    setReq(1, 1'b1, 1'b0, 30'd7, 4'hF, 32'h0); step();
    clearReq(1);
    checkVal("wld_c1", complete[1], 0); step();
    checkVal("wld_c2", complete[1], 0);
    setReq(1, 1'b1, 1'b0, 30'd7, 4'hF, 32'h0); step();
    clearReq(1);
    checkVal("wld_c3", complete[1], 0); step();
    checkVal("wld_c4", complete[1], 1);
    checkVal("wld_data", rdDBus[1], 32'h12345678);
    nCmpl = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (complete[1]) nCmpl++;
    end
    checkVal("wld_single", nCmpl, 0);

    // Aborted store never reaches memory
    setReq(1, 1'b0, 1'b1, 30'd7, 4'hF, 32'hAAAA5555); step();
    clearReq(1);
    abortReq[1] = 1'b1; step();
    abortReq[1] = 1'b0;
    checkVal("abt_c2", complete[1], 0); step();
    checkVal("abt_c3", complete[1], 0); step();
    setReq(1, 1'b1, 1'b0, 30'd7, 4'hF, 32'h0); step();
    clearReq(1);
    step(); step(); step();
    checkVal("abt_data", rdDBus[1], 32'h12345678);
    step();

    // Abort during DONE is ignored
    setReq(1, 1'b0, 1'b1, 30'd7, 4'hF, 32'hCAFEF00D); step();
    clearReq(1);
    step(); step();
    checkVal("abtd_cmpl", complete[1], 1);
    abortReq[1] = 1'b1; step();
    abortReq[1] = 1'b0;
    setReq(1, 1'b1, 1'b0, 30'd7, 4'hF, 32'h0); step();
    clearReq(1);
    step(); step(); step();
    checkVal("abtd_data", rdDBus[1], 32'hCAFEF00D);
    step();

    // Range checks against BASE_ADDR 0x800
    setReq(2, 1'b1, 1'b0, 30'h000, 4'hF, 32'h0); step();
    clearReq(2);
    checkVal("rng_err", rangeErr[2], 1);
    checkVal("rng_cmpl", complete[2], 0); step();
    checkVal("rng_err_pulse", rangeErr[2], 0);
    checkVal("rng_cmpl2", complete[2], 0);
    setReq(2, 1'b0, 1'b1, 30'h805, 4'hF, 32'h5A5A1234); step();
    clearReq(2);
    step(); step();
    checkVal("rng_st_c3", complete[2], 0); step();
    checkVal("rng_st_c4", complete[2], 1);
    setReq(2, 1'b1, 1'b0, 30'h805, 4'hF, 32'h0); step();
    clearReq(2);
    checkVal("rng_ld_cmpl", complete[2], 1);
    checkVal("rng_ld_data", rdDBus[2], 32'h5A5A1234);
    checkVal("rng_ld_noerr", rangeErr[2], 0);
    step();

    // Reset in cycle 2 of a WR_WAIT=3 store discards it
    setReq(2, 1'b0, 1'b1, 30'h805, 4'hF, 32'h0BADBEEF); step();
    clearReq(2); step();
    rst[2] = 1'b1; step();
    rst[2] = 1'b0;
    checkVal("rstw_cmpl", complete[2], 0);
    checkVal("rstw_rd", rdDBus[2], 0);
    checkVal("rstw_rerr", rangeErr[2], 0);
    nCmpl = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (complete[2]) nCmpl++;
    end
    checkVal("rstw_nocmpl", nCmpl, 0);
    setReq(2, 1'b1, 1'b0, 30'h805, 4'hF, 32'h0); step();
    clearReq(2);
    checkVal("rstw_mem", rdDBus[2], 32'h5A5A1234);
    step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
